multicycle_control: RTL
=======================

# multicycle_control

Sequencing controller for the multi-cycle RV32I datapath. A Moore-style state machine fetches each instruction over a shared instruction/data memory port and steps it through decode, execute, memory and writeback. Each cycle it drives the immediate-extend unit's `ImmSrc`, the ALU operand and result muxes, `ALUControl`, and the write strobes. It waits on a memory ready handshake before leaving any state that uses memory.

## Interface
- No parameters.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  7  instr[6:0] from instruction register.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `zero`  in  1  ALU zero flag, same cycle.
- `mem_ready`  in  1  memory access completes this cycle.
- `ImmSrc`  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- `ALUSrcA`  out  2  00 PC, 01 OldPC, 10 rs1.
- `ALUSrcB`  out  2  00 rs2, 01 ImmExt, 10 constant 4.
- `ResultSrc`  out  2  00 ALUOut, 01 read data, 10 ALUResult.
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- `AdrSrc`  out  1  memory address: 0 PC, 1 Result.
- `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite`  out  1 each  write strobes.
- `illegal_instr`  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, plus JALR_TGT and JALR_LINK when configured.
- `ImmSrc` is decoded combinationally from `opcode` in every state:
  - 0000011/0010011/1100111 give 00.
  - 0100011 gives 01.
  - 1100011 gives 10.
  - 1101111 gives 11.
  - Any other opcode gives 00.
- FETCH: AdrSrc=0, A=00, B=10, ALUOp=add, ResultSrc=10.
  - IRWrite=1 and PCUpdate=1 only when `mem_ready`.
  - Go to DECODE on `mem_ready`; otherwise hold in FETCH.
- DECODE: A=01, B=01, add; this latches the branch/jump target into ALUOut.
  - Next state by opcode: lw/sw → MEMADR, R → EXECR, I-ALU → EXECI, beq → BEQ, jal → JAL, jalr → JALR_TGT.
  - Any other opcode: pulse `illegal_instr`, next state FETCH.
- MEMADR: A=10, B=01, add. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until `mem_ready`, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Hold until `mem_ready`, then FETCH.
- EXECR: A=10, B=00, ALUOp=funct. EXECI: A=10, B=01, ALUOp=funct. Both go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BEQ: A=10, B=00, sub, ResultSrc=00, Branch=1, then FETCH.
- JAL: A=01, B=10, add, ResultSrc=00, PCUpdate=1, then ALUWB (writes the link value OldPC+4).
- `PCWrite` = PCUpdate | (Branch & zero).
- ALU decode:
  - ALUOp add gives 000; sub gives 001.
  - ALUOp funct decodes `funct3`: 000 → sub if funct7b5 & opcode[5], else add; 010 → 101; 110 → 011; 111 → 010.
  - Other `funct3` values give 000.
- Reset: state=FETCH. While `rst`=1, all four strobes and `illegal_instr` are forced to 0. Mux selects show FETCH values.
- Reset asserted mid-instruction aborts it. No write is issued in the reset cycle, and the next cycle is FETCH.

## Timing
- Cycles per instruction with `mem_ready` held at 1: lw 5, sw 4, R/I 4, beq 3, jal 4, jalr 5, illegal 2.
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs stay constant while holding, and MemWrite stays asserted while MEMWRITE holds.
- Decode of `ImmSrc` and `ALUControl` is zero-latency from the inputs.
- Only `PCWrite` depends combinationally on `zero`, and only in BEQ.
- `illegal_instr` is high for exactly the one DECODE cycle.

## Configuration
- `MC_CTRL_JALR_EN` defined: the jalr opcode (1100111) is supported.
  - JALR_TGT: A=10, B=01, add; ALUOut takes rs1+imm.
  - JALR_LINK: A=01, B=10, ResultSrc=00, PCUpdate=1, then ALUWB.
- Undefined: JALR states are not compiled. Opcode 1100111 in DECODE is illegal and `ImmSrc` still decodes it as 00.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - state enum `mc_state_t`;
  - `ImmSrc` codes;
  - ALUControl codes;
  - opcode localparams;
  - ALUOp enum.
- One sub-module, `alu_decoder`, maps (ALUOp, funct3, funct7b5, opcode[5]) to `ALUControl`. The FSM and the `ImmSrc` decode stay in the top module.

## Test plan
- Reset held 3 cycles with `mem_ready`=1 → all strobes 0. First post-reset cycle is FETCH with IRWrite=PCWrite=1.
- lw (opcode 0000011), `mem_ready`=0 for 2 cycles in MEMREAD → 7-cycle instruction. RegWrite=1 with ResultSrc=01 once, in the final cycle.
- sub (opcode 0110011, funct3=000, funct7b5=1) → ALUControl=001 in EXECR; ALUWB follows with RegWrite=1.
- beq with zero=1, then again with zero=0 → PCWrite=1 in BEQ for the first, 0 for the second. ImmSrc=10 in both.
- jal → ImmSrc=11 in DECODE, PCWrite=1 in JAL, RegWrite=1 in ALUWB; total 4 cycles.
- Opcode 1100111 → with the macro: 5 cycles ending in ALUWB. Without it: `illegal_instr` pulses in cycle 2, then FETCH with no writes.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// immediate formats, mux selects and ALU codes. MC_CTRL_JALR_EN adds the jalr states.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
`ifdef MC_CTRL_JALR_EN
    ,
    S_JALR_TGT,
    S_JALR_LINK
`endif
  } mc_state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // jalr shares the I format whether or not it is executable.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    imm = IMM_I;
    case (op)
      OP_LOAD, OP_ITYPE, OP_JALR: imm = IMM_I;
      OP_STORE:                   imm = IMM_S;
      OP_BRANCH:                  imm = IMM_B;
      OP_JAL:                     imm = IMM_J;
      default:                    imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// alu_decoder: maps ALUOp plus funct3/funct7b5/opcode[5] to the 3-bit ALUControl.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only means sub for register-register ops; addi ignores it.
          3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the multi-cycle RV32I datapath over a shared memory port.
// Define MC_CTRL_JALR_EN to execute jalr; otherwise opcode 1100111 is illegal.
module multicycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       illegal_instr
);

  mc_state_t state;
  mc_state_t state_next;
  mc_state_t state_eff;
  alu_op_t   alu_op;
  logic      pc_update;
  logic      branch;
  logic      ir_write;
  logic      reg_write;
  logic      mem_write;
  logic      illegal;
  logic      opcode_known;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    opcode_known = 1'b1;
    case (opcode)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: opcode_known = 1'b1;
`ifdef MC_CTRL_JALR_EN
      OP_JALR: opcode_known = 1'b1;
`endif
      default: opcode_known = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
`ifdef MC_CTRL_JALR_EN
          OP_JALR:           state_next = S_JALR_TGT;
`endif
          default:           state_next = S_FETCH;
        endcase
      end
      S_MEMADR:    state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:   state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:     state_next = S_FETCH;
      S_MEMWRITE:  state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:     state_next = S_ALUWB;
      S_EXECI:     state_next = S_ALUWB;
      S_ALUWB:     state_next = S_FETCH;
      S_BEQ:       state_next = S_FETCH;
      S_JAL:       state_next = S_ALUWB;
`ifdef MC_CTRL_JALR_EN
      S_JALR_TGT:  state_next = S_JALR_LINK;
      S_JALR_LINK: state_next = S_ALUWB;
`endif
      default:     state_next = S_FETCH;
    endcase
  end

  // While rst is high the datapath sees FETCH selects, so an aborted instruction
  // never leaves a stray mux setting behind.
  assign state_eff = rst ? S_FETCH : state;

  always_comb begin
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    AdrSrc    = 1'b0;
    alu_op    = ALUOP_ADD;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    illegal   = 1'b0;
    case (state_eff)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        ir_write  = mem_ready;
        pc_update = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        illegal = ~opcode_known;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
`ifdef MC_CTRL_JALR_EN
      S_JALR_TGT: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_JALR_LINK: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign ImmSrc        = imm_src_of(opcode);
  assign IRWrite       = ir_write & ~rst;
  assign RegWrite      = reg_write & ~rst;
  assign MemWrite      = mem_write & ~rst;
  assign illegal_instr = illegal & ~rst;
  assign PCWrite       = (pc_update | (branch & zero)) & ~rst;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (opcode[5]),
    .alu_control (ALUControl)
  );

endmodule
